// File: rtl/p10_host_pkg.sv
// p10 protocol shared definitions for the host (initiator) side.
// Contents:
//   prm_entry_t / PRM_COUNT   parameter RAM entry type and depth
//   PRM_W, PRM_BYTES, PRM_AW  entry width, bytes per entry on the wire, index width
//   P10_SYNC_REQ/RSP          frame sync bytes
//   P10_CMD_RD/WR             command bytes
//   p10_err_t                 transaction result code
//   p10_host_state_t          host sequencer states (also exported on dbg_state)
//   prm_xor()                 XOR of all wire bytes of one entry
package p10_host_pkg;

  localparam int PRM_COUNT = 16;
  typedef logic [15:0] prm_entry_t;

  localparam int PRM_W     = $bits(prm_entry_t);
  localparam int PRM_BYTES = (PRM_W + 7) / 8;
  localparam int PRM_AW    = $clog2(PRM_COUNT + 1);

  // Entry padded up to a whole number of bytes, as it travels on the wire.
  typedef logic [PRM_BYTES*8-1:0] prm_pad_t;

  localparam logic [7:0] P10_SYNC_REQ = 8'hA5;
  localparam logic [7:0] P10_SYNC_RSP = 8'h5A;
  localparam logic [7:0] P10_CMD_RD   = 8'h01;
  localparam logic [7:0] P10_CMD_WR   = 8'h02;

  typedef enum logic [1:0] {
    P10_OK      = 2'd0,
    P10_REMOTE  = 2'd1,
    P10_CSUM    = 2'd2,
    P10_TIMEOUT = 2'd3
  } p10_err_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_TX_SYNC = 4'd1,
    ST_TX_CMD  = 4'd2,
    ST_TX_ADDR = 4'd3,
    ST_TX_DATA = 4'd4,
    ST_TX_CSUM = 4'd5,
    ST_RX_SYNC = 4'd6,
    ST_RX_STAT = 4'd7,
    ST_RX_DATA = 4'd8,
    ST_RX_CSUM = 4'd9,
    ST_DONE    = 4'd10
  } p10_host_state_t;

  // Checksum contribution of the data bytes of one entry.
  function automatic logic [7:0] prm_xor(input prm_entry_t d);
    prm_pad_t   pad;
    logic [7:0] acc;
    pad = prm_pad_t'(d);
    acc = 8'h00;
    for (int i = 0; i < PRM_BYTES; i++) begin
      acc = acc ^ pad[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/p10_host_txser.sv
// p10_host_txser: single-byte emitter toward the uart.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   byte_v, byte_d    byte offered by the sequencer (held until byte_done)
//   byte_done         1-cycle pulse: the offered byte went out this cycle
//   txd, txv          byte and strobe to the uart
//   cts               uart can take a byte this cycle
// Handshake: the sequencer holds byte_v/byte_d stable until byte_done.
// The byte is captured into txd while idle, then strobed (txv=1 for one
// cycle) in the first cycle where cts=1 and the post-strobe gap has expired.
// txv is combinational on cts so it can only ever be high in a cts=1 cycle.
module p10_host_txser #(
  parameter int TX_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_v,
  input  logic [7:0] byte_d,
  output logic       byte_done,
  output logic [7:0] txd,
  output logic       txv,
  input  logic       cts
);

  localparam int              GW       = $clog2(TX_GAP + 2);
  // Loaded on a strobe; counts down 1+TX_GAP idle cycles before the next one.
  localparam logic [GW-1:0]   GAP_LOAD = GW'(TX_GAP + 1);

  logic          pend;
  logic [GW-1:0] gap_cnt;
  logic          fire;

  assign fire      = pend && cts && (gap_cnt == '0);
  assign txv       = fire;
  assign byte_done = fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= 1'b0;
      txd     <= 8'h00;
      gap_cnt <= '0;
    end else if (fire) begin
      pend    <= 1'b0;
      gap_cnt <= GAP_LOAD;
    end else begin
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (!pend && byte_v) begin
        pend <= 1'b1;
        txd  <= byte_d;
      end
    end
  end

endmodule

// File: rtl/p10_host.sv
// p10_host: initiator side of the p10 parameter protocol.
// Sends a request frame  A5, CMD, ADDR, [data MSB first, writes only], CSUM
// and parses the reply   5A, STATUS, [data, reads with STATUS==0], CSUM.
// CSUM is the XOR of every byte after the sync byte.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_v/req_rdy              request handshake (accepted when both high)
//   req_we, req_addr, req_d    write enable, parameter index, write data
//   rsp_v                      1-cycle pulse when a transaction finishes
//   rsp_q                      read data, held until the next rsp_v
//   rsp_err                    p10_err_t: OK / REMOTE / CSUM / TIMEOUT
//   txd, txv, cts              byte stream to the uart
//   rxd, rxv                   byte stream from the uart
//   busy                       high from accept until rsp_v
//   dbg_state                  current sequencer state (p10_host_state_t)
// Build option: define P10_HOST_TIMEOUT_EN to abort a reply that stalls for
// TIMEOUT_CYCLES cycles between bytes; otherwise the reply is awaited forever.
module p10_host
  import p10_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int          TX_GAP         = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_v,
  input  logic              req_we,
  input  logic [PRM_AW-1:0] req_addr,
  input  logic [PRM_W-1:0]  req_d,
  output logic              req_rdy,
  output logic              rsp_v,
  output logic [PRM_W-1:0]  rsp_q,
  output logic [1:0]        rsp_err,
  output logic [7:0]        txd,
  output logic              txv,
  input  logic              cts,
  input  logic [7:0]        rxd,
  input  logic              rxv,
  output logic              busy,
  output logic [3:0]        dbg_state
);

  localparam int IW = $clog2(PRM_BYTES) + 1;

  p10_host_state_t   state, state_nxt;

  logic              we_q;
  logic [PRM_AW-1:0] addr_q;
  prm_pad_t          tx_sh;
  prm_pad_t          rx_sh;
  logic [7:0]        tx_csum;
  logic [7:0]        rx_csum;
  logic              stat_nz;
  logic [IW-1:0]     idx;
  logic              last_idx;
  logic [PRM_W-1:0]  rsp_q_r;
  p10_err_t          rsp_err_r;

  logic              byte_v;
  logic [7:0]        byte_d;
  logic              byte_done;
  logic              to_hit;

  assign last_idx = (idx == IW'(PRM_BYTES - 1));

  // ---------------------------------------------------------------- timeout
`ifdef P10_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          in_rx;

  assign in_rx = state inside {ST_RX_SYNC, ST_RX_STAT, ST_RX_DATA, ST_RX_CSUM};

  // Counts cycles since RX_SYNC entry or the last received byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               to_cnt <= '0;
    else if (!in_rx || rxv) to_cnt <= '0;
    else                    to_cnt <= to_cnt + 1'b1;
  end

  // A byte arriving on the limit cycle still counts as in time.
  assign to_hit = in_rx && !rxv && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // -------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req_v)     state_nxt = ST_TX_SYNC;
      ST_TX_SYNC: if (byte_done) state_nxt = ST_TX_CMD;
      ST_TX_CMD:  if (byte_done) state_nxt = ST_TX_ADDR;
      ST_TX_ADDR: if (byte_done) state_nxt = we_q ? ST_TX_DATA : ST_TX_CSUM;
      ST_TX_DATA: if (byte_done && last_idx) state_nxt = ST_TX_CSUM;
      ST_TX_CSUM: if (byte_done) state_nxt = ST_RX_SYNC;
      ST_RX_SYNC: begin
        if (rxv && rxd == P10_SYNC_RSP) state_nxt = ST_RX_STAT;
        else if (to_hit)                state_nxt = ST_DONE;
      end
      ST_RX_STAT: begin
        if (rxv)         state_nxt = (!we_q && rxd == 8'h00) ? ST_RX_DATA : ST_RX_CSUM;
        else if (to_hit) state_nxt = ST_DONE;
      end
      ST_RX_DATA: begin
        if (rxv && last_idx) state_nxt = ST_RX_CSUM;
        else if (to_hit)     state_nxt = ST_DONE;
      end
      ST_RX_CSUM: begin
        if (rxv || to_hit) state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    req_rdy = (state == ST_IDLE);
    busy    = (state != ST_IDLE);
    rsp_v   = (state == ST_DONE);
    byte_v  = 1'b0;
    byte_d  = 8'h00;
    case (state)
      ST_TX_SYNC: begin byte_v = 1'b1; byte_d = P10_SYNC_REQ; end
      ST_TX_CMD:  begin byte_v = 1'b1; byte_d = we_q ? P10_CMD_WR : P10_CMD_RD; end
      ST_TX_ADDR: begin byte_v = 1'b1; byte_d = 8'(addr_q); end
      ST_TX_DATA: begin byte_v = 1'b1; byte_d = tx_sh[PRM_BYTES*8-1 -: 8]; end
      ST_TX_CSUM: begin byte_v = 1'b1; byte_d = tx_csum; end
      default:    ;
    endcase
  end

  assign rsp_q     = rsp_q_r;
  assign rsp_err   = rsp_err_r;
  assign dbg_state = state;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      tx_csum   <= 8'h00;
      rx_csum   <= 8'h00;
      stat_nz   <= 1'b0;
      idx       <= '0;
      rsp_q_r   <= '0;
      rsp_err_r <= P10_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_v) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            tx_sh   <= prm_pad_t'(req_d);
            // Whole request checksum is known at accept time.
            tx_csum <= (req_we ? P10_CMD_WR : P10_CMD_RD) ^ 8'(req_addr)
                       ^ (req_we ? prm_xor(req_d) : 8'h00);
            idx     <= '0;
          end
        end
        ST_TX_DATA: begin
          if (byte_done) begin
            tx_sh <= tx_sh << 8;
            idx   <= idx + 1'b1;
          end
        end
        ST_RX_SYNC: begin
          rx_csum <= 8'h00;
          stat_nz <= 1'b0;
          idx     <= '0;
        end
        ST_RX_STAT: begin
          if (rxv) begin
            rx_csum <= rxd;
            stat_nz <= (rxd != 8'h00);
          end
        end
        ST_RX_DATA: begin
          if (rxv) begin
            rx_csum <= rx_csum ^ rxd;
            rx_sh   <= (rx_sh << 8) | prm_pad_t'(rxd);
            idx     <= idx + 1'b1;
          end
        end
        ST_RX_CSUM: begin
          if (rxv) begin
            // A remote rejection is reported even if its checksum is also bad.
            if (stat_nz)             rsp_err_r <= P10_REMOTE;
            else if (rx_csum != rxd) rsp_err_r <= P10_CSUM;
            else begin
              rsp_err_r <= P10_OK;
              if (!we_q) rsp_q_r <= rx_sh[PRM_W-1:0];
            end
          end
        end
        default: ;
      endcase
      if (to_hit) rsp_err_r <= P10_TIMEOUT;
    end
  end

  // ------------------------------------------------------------ byte emitter
  p10_host_txser #(
    .TX_GAP(TX_GAP)
  ) u_txser (
    .clk       (clk),
    .rst       (rst),
    .byte_v    (byte_v),
    .byte_d    (byte_d),
    .byte_done (byte_done),
    .txd       (txd),
    .txv       (txv),
    .cts       (cts)
  );

endmodule
